mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares one sram-like memory bus between the fetch-stage instruction port and the mem-stage data port of the five-stage pipeline. One transaction is outstanding at a time. The block returns per-port completion pulses and stall requests to the hazard unit. It sits between the CPU core (fetch PC / mem-stage address) and the cache or AXI bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch read request; held until inst_data_ok
- inst_addr  in  ADDR_W  fetch address (pcF)
- inst_rdata  out  DATA_W  instruction, valid with inst_data_ok
- inst_data_ok  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held until data_data_ok
- data_wr  in  1  1 = store
- data_wstrb  in  4  byte enables (memwrite2M)
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data (writedata2M)
- data_rdata  out  DATA_W  load data, valid with data_data_ok
- data_data_ok  out  1  one-cycle completion pulse
- flush  in  1  exception flush; discards an in-flight instruction fetch
- stall_inst, stall_data  out  1  = port req & ~port data_ok
- bus_req, bus_wr  out  1  bus request / write
- bus_wstrb  out  4  byte enables (0 for reads)
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok, bus_data_ok  in  1  bus address accepted / response valid
- bus_rdata  in  DATA_W  bus read data

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register: INST or DATA. Discard flag: 1 bit.
- IDLE: if any req is pending, latch the grant and the winner's addr/wr/wstrb/wdata into the request register, then go to ADDR. Otherwise stay in IDLE.
- Grant priority: data beats inst.
- ADDR: bus_req=1, driven from the request register. On bus_addr_ok, go to DATA. bus_req is never withdrawn before addr_ok.
- DATA: bus_req=0. On bus_data_ok:
  - Pulse the owner's data_ok with rdata = bus_rdata (combinational pass-through).
  - Go to IDLE.
  - If the discard flag is set, suppress inst_data_ok and clear the flag.
- Flush:
  - Sets the discard flag when the owner is INST and the state is ADDR or DATA. The transaction is then completed on the bus and silently dropped.
  - In IDLE, flush has no effect.
  - A flush never aborts a DATA-owner transaction.
- Flush and bus_data_ok in the same cycle with owner INST: the response is discarded.
- The non-owner port's data_ok stays 0. Its rdata outputs are don't-care.
- stall_inst / stall_data are combinational from req and data_ok.
- Reset: state=IDLE, owner=INST, discard=0, last-served=INST, all bus_* outputs 0, both data_ok outputs 0.
- Reset mid-transaction drops the transaction. The bus slave is reset by the same rst.

## Timing
- Request seen at cycle N in IDLE: bus_req is 1 at N+1.
- With bus_addr_ok at N+1 and bus_data_ok at N+2, the port data_ok is at N+2. Minimum latency is 2 cycles.
- Re-arbitration happens in the cycle after data_ok. Back-to-back transactions are therefore spaced 3 cycles minimum.
- A requester must drop or change its req in the cycle after its data_ok. The arbiter does not sample req in a cycle where it is not in IDLE.
- bus_* outputs are registered and stable throughout ADDR.

## Configuration
- MEM_ARB_RR_EN defined: round-robin grant. When both ports request in IDLE, the grant goes to the port not in last-served. last-served updates at each grant.
- MEM_ARB_RR_EN undefined: fixed data-over-inst priority. The last-served register is not instantiated.

## Structure
- Package mem_arb_pkg:
  - arb_state_t {IDLE, ADDR, DATA}
  - owner_t {OWN_INST, OWN_DATA}
  - strobe-width constant
- Single module, no sub-modules. The request register is inline.

## Test plan
- Inst-only: inst_req, addr 0xBFC00000, bus_addr_ok at N+1, bus_data_ok at N+2 with rdata 0x24080001 -> inst_data_ok pulse at N+2 with that data; bus_wstrb=0.
- Simultaneous inst and data store (addr 0x80000010, wstrb 0xF, wdata 0xDEADBEEF) -> data granted first. The inst transaction starts the cycle after data_data_ok. stall_inst stays high throughout.
- Flush at the cycle of bus_addr_ok for an inst fetch -> bus completes, inst_data_ok stays 0, next inst_req is served normally.
- bus_addr_ok delayed 5 cycles -> bus_req and bus_addr are held constant for 5 cycles, no duplicate request.
- rst asserted in DATA state -> next cycle state IDLE, bus_req=0, both data_ok=0.
- With MEM_ARB_RR_EN: both ports requesting continuously -> grants alternate DATA, INST, DATA, INST.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam int unsigned STRB_W = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and mem-stage ports onto one sram-like bus, one transaction at a time.
// Optional round-robin grant is enabled by defining MEM_ARB_RR_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,

    input  logic              flush,
    output logic              stall_inst,
    output logic              stall_data,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t state;
    owner_t     owner;
    owner_t     grant;
    logic       discard;
    logic       respValid;
    logic       instFlush;

`ifdef MEM_ARB_RR_EN
    owner_t     lastServed;

    always_comb begin
        grant = OWN_INST;
        if (data_req && inst_req) begin
            grant = (lastServed == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else if (data_req) begin
            grant = OWN_DATA;
        end
    end
`else
    always_comb begin
        grant = data_req ? OWN_DATA : OWN_INST;
    end
`endif

    assign instFlush = flush && (owner == OWN_INST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_INST;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            lastServed <= OWN_INST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        owner   <= grant;
                        state   <= ADDR;
                        bus_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        lastServed <= grant;
`endif
                        if (grant == OWN_DATA) begin
                            bus_wr    <= data_wr;
                            bus_wstrb <= data_wr ? data_wstrb : '0;
                            bus_addr  <= data_addr;
                            bus_wdata <= data_wdata;
                        end else begin
                            bus_wr    <= 1'b0;
                            bus_wstrb <= '0;
                            bus_addr  <= inst_addr;
                            bus_wdata <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (instFlush) begin
                        discard <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    // A flush coinciding with the response is handled by the output gating below.
                    if (bus_data_ok) begin
                        discard <= 1'b0;
                        state   <= IDLE;
                    end else if (instFlush) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign respValid    = (state == DATA) && bus_data_ok && !rst;
    assign inst_data_ok = respValid && (owner == OWN_INST) && !discard && !flush;
    assign data_data_ok = respValid && (owner == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign stall_inst = inst_req && !inst_data_ok;
    assign stall_data = data_req && !data_data_ok;

endmodule
